// File: rtl/shift_pkg.sv
// Shared types for the parametrised shift register: shift modes and FSM states.
// Combinational declarations only; there is no latency and no backpressure here.
package shift_pkg;

  typedef enum logic [1:0] {
    LSR = 2'd0,
    LSL = 2'd1,
    ROR = 2'd2,
    ASR = 2'd3
  } shift_mode_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } shift_state_e;

endpackage

// File: rtl/shift_reg_param_if.sv
// Control and data bundle between a shift register and its user.
// Pure wiring: no latency, and flow control is the busy/done pair on the slave side.
interface shift_reg_param_if #(
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(WIDTH + 1)
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             ena;
  logic [1:0]       mode;
  logic             sin;
  logic             start;
  logic [AW-1:0]    amount;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output load, data, ena, mode, sin, start, amount,
    input  q, sout, busy, done
  );

  modport slave (
    input  load, data, ena, mode, sin, start, amount,
    output q, sout, busy, done
  );
endinterface

// File: rtl/shift_unit.sv
// One-position combinational shifter for LSR/LSL/ROR/ASR with serial in/out.
// Zero latency, no backpressure.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  shift_mode_e      mode,
  input  logic             sin,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = q[0];
    case (mode)
      LSR: q_next = {sin, q[WIDTH-1:1]};
      LSL: begin
        q_next  = {q[WIDTH-2:0], sin};
        out_bit = q[WIDTH-1];
      end
      ROR: q_next = {q[0], q[WIDTH-1:1]};
      ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_param.sv
// Shift register with load, single-step shift and counted shift-by-N; all outputs registered.
// Counted shift: busy one edge after start, done N edges later; ena low stalls one cycle each.
module shift_reg_param
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              reset,
  shift_reg_param_if.slave bus
);

  shift_state_e     state;
  logic [AW-1:0]    cnt;
  shift_mode_e      mode_lat;
  logic [WIDTH-1:0] q_r;
  logic             sout_r;
  logic             done_r;

  shift_mode_e      cur_mode;
  logic [WIDTH-1:0] q_next;
  logic             out_bit;

  // Once busy, the mode captured at start governs every step.
  assign cur_mode = (state == BUSY) ? mode_lat : shift_mode_e'(bus.mode);

  shift_unit #(.WIDTH(WIDTH)) u_shift (
    .q       (q_r),
    .mode    (cur_mode),
    .sin     (bus.sin),
    .q_next  (q_next),
    .out_bit (out_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_lat <= LSR;
      q_r      <= '0;
      sout_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.load) begin
        q_r    <= bus.data;
        sout_r <= 1'b0;
        state  <= IDLE;
        cnt    <= '0;
      end else if (state == IDLE) begin
        if (bus.start) begin
          if (bus.amount == '0) begin
            done_r <= 1'b1;
          end else begin
            cnt      <= bus.amount;
            mode_lat <= shift_mode_e'(bus.mode);
            state    <= BUSY;
          end
        end else if (bus.ena) begin
          q_r    <= q_next;
          sout_r <= out_bit;
        end
      end else if (bus.ena) begin
        q_r    <= q_next;
        sout_r <= out_bit;
        cnt    <= cnt - AW'(1);
        if (cnt == AW'(1)) begin
          state  <= IDLE;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.sout = sout_r;
  assign bus.busy = (state == BUSY);
  assign bus.done = done_r;

endmodule

// File: tb/tb_shift_reg_param.sv
// Directed-vector bench for shift_reg_param at WIDTH=8; one task per scenario.
module tb_shift_reg_param;
  localparam int WIDTH = 8;
  localparam int AW    = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  shift_reg_param_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  shift_reg_param #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.load = 1'b0; bus.data = '0; bus.ena = 1'b0; bus.mode = 2'd0;
    bus.sin = 1'b0; bus.start = 1'b0; bus.amount = '0;
  endtask

  task automatic do_load(input logic [7:0] v);
    quiet();
    bus.load = 1'b1; bus.data = v;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    int seen_done;
    reset = 1'b1;
    tick(); tick();
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL rst_q got %h exp 00", bus.q); end
    checks++; if (bus.sout !== 1'b0) begin errors++; $display("FAIL rst_sout got %b exp 0", bus.sout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
    reset = 1'b0;
    do_load(8'h5A);
    bus.start = 1'b1; bus.amount = 4'd5; bus.mode = 2'd2; bus.ena = 1'b1;
    seen_done = 0;
    tick();
    bus.start = 1'b0;
    seen_done += int'(bus.done);
    tick(); seen_done += int'(bus.done);
    tick(); seen_done += int'(bus.done);
    checks++; if (bus.q !== 8'h96 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_op got q=%h busy=%b exp q=96 busy=1", bus.q, bus.busy); end
    reset = 1'b1;
    tick(); seen_done += int'(bus.done);
    checks++; if (bus.q !== 8'h00 || bus.sout !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid got q=%h sout=%b busy=%b exp 00/0/0", bus.q, bus.sout, bus.busy); end
    reset = 1'b0;
    quiet();
    tick(); seen_done += int'(bus.done);
    tick(); seen_done += int'(bus.done);
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rst_no_done got %0d pulses exp 0", seen_done); end
  endtask

  task automatic test_single();
    do_load(8'hA5);
    bus.ena = 1'b1; bus.mode = 2'd0; bus.sin = 1'b1;
    tick();
    checks++; if (bus.q !== 8'hD2 || bus.sout !== 1'b1) begin errors++; $display("FAIL lsr got q=%h sout=%b exp D2/1", bus.q, bus.sout); end
    bus.mode = 2'd1; bus.sin = 1'b0;
    tick();
    checks++; if (bus.q !== 8'hA4 || bus.sout !== 1'b1) begin errors++; $display("FAIL lsl got q=%h sout=%b exp A4/1", bus.q, bus.sout); end
    quiet();
  endtask

  task automatic test_asr();
    do_load(8'h96);
    bus.ena = 1'b1; bus.mode = 2'd3;
    tick();
    checks++; if (bus.q !== 8'hCB || bus.sout !== 1'b0) begin errors++; $display("FAIL asr1 got q=%h sout=%b exp CB/0", bus.q, bus.sout); end
    tick();
    checks++; if (bus.q !== 8'hE5 || bus.sout !== 1'b1) begin errors++; $display("FAIL asr2 got q=%h sout=%b exp E5/1", bus.q, bus.sout); end
    quiet();
  endtask

  task automatic test_counted_ror();
    do_load(8'h81);
    bus.start = 1'b1; bus.amount = 4'd3; bus.mode = 2'd2; bus.ena = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.q !== 8'h81) begin errors++; $display("FAIL ror_e1 got busy=%b q=%h exp 1/81", bus.busy, bus.q); end
    tick();
    checks++; if (bus.q !== 8'hC0 || bus.busy !== 1'b1) begin errors++; $display("FAIL ror_e2 got q=%h busy=%b exp C0/1", bus.q, bus.busy); end
    bus.mode = 2'd1;
    tick();
    checks++; if (bus.q !== 8'h60 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL ror_e3 got q=%h busy=%b done=%b exp 60/1/0", bus.q, bus.busy, bus.done); end
    tick();
    checks++; if (bus.q !== 8'h30 || bus.sout !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin errors++; $display("FAIL ror_done got q=%h sout=%b busy=%b done=%b exp 30/0/0/1", bus.q, bus.sout, bus.busy, bus.done); end
    quiet();
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ror_done_pulse got %b exp 0", bus.done); end
  endtask

  task automatic test_stall_abort();
    do_load(8'h0F);
    bus.start = 1'b1; bus.amount = 4'd4; bus.mode = 2'd1; bus.sin = 1'b0; bus.ena = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    checks++; if (bus.q !== 8'h3C) begin errors++; $display("FAIL stall_pre got q=%h exp 3C", bus.q); end
    bus.ena = 1'b0;
    tick(); tick();
    checks++; if (bus.q !== 8'h3C || bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL stall_hold got q=%h busy=%b done=%b exp 3C/1/0", bus.q, bus.busy, bus.done); end
    bus.ena = 1'b1;
    tick();
    checks++; if (bus.q !== 8'h78 || bus.done !== 1'b0) begin errors++; $display("FAIL stall_e6 got q=%h done=%b exp 78/0", bus.q, bus.done); end
    tick();
    checks++; if (bus.q !== 8'hF0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL stall_done got q=%h done=%b busy=%b exp F0/1/0", bus.q, bus.done, bus.busy); end
    do_load(8'h0F);
    bus.start = 1'b1; bus.amount = 4'd4; bus.mode = 2'd1; bus.ena = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.load = 1'b1; bus.data = 8'h3C;
    tick();
    checks++; if (bus.q !== 8'h3C || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sout !== 1'b0) begin errors++; $display("FAIL abort got q=%h busy=%b done=%b sout=%b exp 3C/0/0/0", bus.q, bus.busy, bus.done, bus.sout); end
    quiet();
    tick();
    checks++; if (bus.done !== 1'b0 || bus.q !== 8'h3C) begin errors++; $display("FAIL abort_after got done=%b q=%h exp 0/3C", bus.done, bus.q); end
  endtask

  task automatic test_edge();
    do_load(8'h5A);
    bus.start = 1'b1; bus.amount = 4'd0;
    tick();
    checks++; if (bus.done !== 1'b1 || bus.q !== 8'h5A || bus.busy !== 1'b0) begin errors++; $display("FAIL amt0 got done=%b q=%h busy=%b exp 1/5A/0", bus.done, bus.q, bus.busy); end
    bus.start = 1'b0;
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL amt0_pulse got %b exp 0", bus.done); end
    bus.start = 1'b1; bus.amount = 4'd2; bus.mode = 2'd2; bus.ena = 1'b1;
    tick();
    bus.amount = 4'd5;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (bus.done !== 1'b1 || bus.q !== 8'h96 || bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start got done=%b q=%h busy=%b exp 1/96/0", bus.done, bus.q, bus.busy); end
    bus.start = 1'b1; bus.amount = 4'd1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.q !== 8'h4B) begin errors++; $display("FAIL b2b_done got done=%b q=%h exp 1/4B", bus.done, bus.q); end
    do_load(8'h5A);
    bus.start = 1'b1; bus.amount = 4'd8; bus.mode = 2'd2; bus.ena = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL ror8_pre got done=%b busy=%b exp 0/1", bus.done, bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.q !== 8'h5A) begin errors++; $display("FAIL ror8 got done=%b q=%h exp 1/5A", bus.done, bus.q); end
    quiet();
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    test_reset();
    test_single();
    test_asr();
    test_counted_ror();
    test_stall_abort();
    test_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
